// File: rtl/alu_muldiv_seq.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider
// sharing one product/quotient register, sequenced by a four-state FSM.
module alu_muldiv_seq #(
  parameter int DATA_WIDTH   = 32,
  parameter int FUNCT_LENGTH = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    Start,
  input  logic [FUNCT_LENGTH-1:0] Funct3,
  input  logic [DATA_WIDTH-1:0]   SrcA,
  input  logic [DATA_WIDTH-1:0]   SrcB,
  output logic                    Busy,
  output logic                    Done,
  output logic [DATA_WIDTH-1:0]   MulDivResult
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [FUNCT_LENGTH-1:0] funct_q, funct_d;
  logic [2*W-1:0]          acc_q, acc_d;
  logic [W:0]              rem_q, rem_d;
  logic [W-1:0]            opb_q, opb_d;
  logic                    neg_q, neg_d;
  logic                    spec_q, spec_d;
  logic [W-1:0]            result_q, result_d;

  function automatic logic [W-1:0] apply_sign(input logic [W-1:0] v, input logic s);
    return s ? -v : v;
  endfunction

  function automatic logic [2*W-1:0] apply_sign2(input logic [2*W-1:0] v, input logic s);
    return s ? -v : v;
  endfunction

  // Operand conditioning for a newly accepted op
  logic [2:0]     cap_f;
  logic           cap_is_div, cap_a_signed, cap_b_signed, cap_sa, cap_sb;
  logic [W-1:0]   cap_mag_a, cap_mag_b, cap_spec_val, cap_opb;
  logic           cap_neg, cap_div_zero, cap_ovf, cap_special;
  logic [2*W-1:0] cap_acc;

  always_comb begin
    cap_f        = Funct3[2:0];
    cap_is_div   = cap_f[2];
    cap_a_signed = cap_is_div ? ~cap_f[0] : (cap_f[1:0] == 2'b01 || cap_f[1:0] == 2'b10);
    cap_b_signed = cap_is_div ? ~cap_f[0] : (cap_f[1:0] == 2'b01);
    cap_sa       = cap_a_signed & SrcA[W-1];
    cap_sb       = cap_b_signed & SrcB[W-1];
    cap_mag_a    = apply_sign(SrcA, cap_sa);
    cap_mag_b    = apply_sign(SrcB, cap_sb);
    // Remainder takes the dividend's sign; everything else the product of signs
    cap_neg      = (cap_is_div && cap_f[1]) ? cap_sa : (cap_sa ^ cap_sb);
    cap_div_zero = cap_is_div && (SrcB == '0);
    cap_ovf      = cap_is_div && !cap_f[0] && (SrcA == MOST_NEG) && (SrcB == '1);
    cap_special  = cap_div_zero || cap_ovf;
    if (cap_div_zero) cap_spec_val = cap_f[1] ? SrcA : '1;
    else              cap_spec_val = cap_f[1] ? '0 : MOST_NEG;
    if (cap_special)     cap_acc = {{W{1'b0}}, cap_spec_val};
    else if (cap_is_div) cap_acc = {{W{1'b0}}, cap_mag_a};
    else                 cap_acc = {{W{1'b0}}, cap_mag_b};
    cap_opb = cap_is_div ? cap_mag_b : cap_mag_a;
  end

  // One iteration of each datapath, plus final result selection
  logic [W:0]     mul_sum;
  logic [W+1:0]   div_shift, div_diff;
  logic           div_borrow;
  logic [2*W-1:0] mul_full;
  logic [W-1:0]   quo_fix, rem_fix;

  always_comb begin
    mul_sum    = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
    div_shift  = {rem_q, acc_q[W-1]};
    div_diff   = div_shift - {2'b00, opb_q};
    div_borrow = div_diff[W+1];
    mul_full   = apply_sign2(acc_q, neg_q);
    quo_fix    = apply_sign(acc_q[W-1:0], neg_q);
    rem_fix    = apply_sign(rem_q[W-1:0], neg_q);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    funct_d  = funct_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    spec_d   = spec_q;
    result_d = result_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          funct_d = Funct3;
          acc_d   = cap_acc;
          rem_d   = '0;
          opb_d   = cap_opb;
          neg_d   = cap_neg;
          spec_d  = cap_special;
          cnt_d   = '0;
          state_d = cap_special ? S_FIX : S_RUN;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (funct_q[2]) begin
          rem_d = div_borrow ? div_shift[W:0] : div_diff[W:0];
          acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], ~div_borrow};
        end else begin
          acc_d = {mul_sum, acc_q[W-1:1]};
        end
        if (cnt_q == CW'(W-1)) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        if (spec_q)                  result_d = acc_q[W-1:0];
        else if (funct_q[2])         result_d = funct_q[1] ? rem_fix : quo_fix;
        else if (funct_q[1:0] == 2'b00) result_d = mul_full[W-1:0];
        else                         result_d = mul_full[2*W-1:W];
        state_d = S_DONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      funct_q  <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      spec_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funct_q  <= funct_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
      spec_q   <= spec_d;
      result_q <= result_d;
    end
  end

  assign Busy         = (state_q != S_IDLE);
  assign Done         = (state_q == S_DONE);
  assign MulDivResult = result_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: directed vector table, multi-cycle corner sequences,
// and randomized ops against a 64-bit arithmetic reference model.
module tb_alu_muldiv_seq;

  localparam int W = 32;
  // Edges from the Start-sampling edge to the first edge after which Done is seen
  localparam int LAT_NORM = W + 1;
  localparam int LAT_SPEC = 1;
  localparam logic [31:0] MOST_NEG = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset, Start, Busy, Done;
  logic [2:0]  Funct3;
  logic [31:0] SrcA, SrcB, MulDivResult;

  alu_muldiv_seq #(.DATA_WIDTH(W), .FUNCT_LENGTH(3)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Funct3(Funct3),
    .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .Done(Done),
    .MulDivResult(MulDivResult)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint          p;
    longint unsigned pu;
    logic [31:0]     r;
    r = '0;
    case (f)
      3'd0: begin pu = ua * ub; r = pu[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
      3'd3: begin pu = ua * ub; r = pu[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == MOST_NEG && b == 32'hFFFF_FFFF) r = MOST_NEG;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == MOST_NEG && b == 32'hFFFF_FFFF) r = 32'h0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == MOST_NEG && b == 32'hFFFF_FFFF)))
      return LAT_SPEC;
    return LAT_NORM;
  endfunction

  // Present an op, let the next edge sample it, then scramble the inputs
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    Funct3 = f; SrcA = a; SrcB = b; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; SrcA = $urandom; SrcB = $urandom; Funct3 = 3'($urandom);
  endtask

  task automatic wait_done(output int n, output bit busy_low);
    n = 0; busy_low = 1'b0;
    while (n < 200) begin
      if (!Busy) busy_low = 1'b1;
      @(posedge clk); #1; n++;
      if (Done) break;
    end
  endtask

  task automatic run(input string name, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n; bit bl;
    issue(f, a, b);
    wait_done(n, bl);
    chk({name, " result"}, MulDivResult, exp);
    chk({name, " latency"}, 32'(n), 32'(lat));
    chk({name, " busy while running"}, {31'b0, bl}, 32'd0);
    @(posedge clk); #1;
    chk({name, " done single pulse"}, {31'b0, Done}, 32'd0);
    chk({name, " result holds"}, MulDivResult, exp);
  endtask

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic [31:0] a, b, exp;
    int          lat;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m, dseen, bseen; bit bl;
    logic [2:0]  f;
    logic [31:0] a, b;
    int sel;

    tbl[0]  = '{"MUL 7*-3",         3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_NORM};
    tbl[1]  = '{"MULHU -1*-1",      3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_NORM};
    tbl[2]  = '{"MULH -1*-1",       3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, LAT_NORM};
    tbl[3]  = '{"MULHSU -1*2",      3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, LAT_NORM};
    tbl[4]  = '{"DIV -7/2",         3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, LAT_NORM};
    tbl[5]  = '{"REM -7/2",         3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, LAT_NORM};
    tbl[6]  = '{"DIVU 100/7",       3'd5, 32'd100,       32'd7,         32'd14,        LAT_NORM};
    tbl[7]  = '{"REMU 100/7",       3'd7, 32'd100,       32'd7,         32'd2,         LAT_NORM};
    tbl[8]  = '{"DIVU 5/0",         3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, LAT_SPEC};
    tbl[9]  = '{"REM 5/0",          3'd6, 32'd5,         32'd0,         32'd5,         LAT_SPEC};
    tbl[10] = '{"DIV ovf",          3'd4, MOST_NEG,      32'hFFFF_FFFF, MOST_NEG,      LAT_SPEC};
    tbl[11] = '{"REM ovf",          3'd6, MOST_NEG,      32'hFFFF_FFFF, 32'd0,         LAT_SPEC};
    tbl[12] = '{"MULH min*min",     3'd1, MOST_NEG,      MOST_NEG,      32'h4000_0000, LAT_NORM};
    tbl[13] = '{"DIV 7/-2",         3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT_NORM};
    tbl[14] = '{"REM 7/-2",         3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         LAT_NORM};

    reset = 1'b1; Start = 1'b0; Funct3 = '0; SrcA = '0; SrcB = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {31'b0, Busy}, 32'd0);
    chk("reset done", {31'b0, Done}, 32'd0);
    chk("reset result", MulDivResult, 32'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) run(tbl[i].name, tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat);

    // Start re-asserted mid-run must be ignored and must not queue
    issue(3'd5, 32'd100, 32'd7);
    n = 0;
    repeat (5) begin @(posedge clk); #1; n++; end
    Start = 1'b1; Funct3 = 3'd0; SrcA = 32'd3; SrcB = 32'd3;
    repeat (3) begin @(posedge clk); #1; n++; end
    Start = 1'b0;
    wait_done(m, bl);
    chk("ignore start result", MulDivResult, 32'd14);
    chk("ignore start latency", 32'(n + m), 32'(LAT_NORM));
    @(posedge clk); #1;
    chk("ignore start no queued op", {31'b0, Busy}, 32'd0);

    // Back-to-back: Start held in the DONE cycle
    issue(3'd0, 32'd7, 32'hFFFF_FFFD);
    wait_done(n, bl);
    chk("b2b first result", MulDivResult, 32'hFFFF_FFEB);
    chk("b2b done and busy", {30'b0, Done, Busy}, 32'd3);
    issue(3'd7, 32'd100, 32'd7);
    chk("b2b no idle bubble", {31'b0, Busy}, 32'd1);
    wait_done(n, bl);
    chk("b2b second result", MulDivResult, 32'd2);
    chk("b2b second latency", 32'(n), 32'(LAT_NORM));
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a divide
    issue(3'd4, 32'hFFFF_FFF9, 32'd2);
    repeat (9) @(posedge clk);
    #1;
    chk("pre-reset busy", {31'b0, Busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("async reset busy", {31'b0, Busy}, 32'd0);
    chk("async reset done", {31'b0, Done}, 32'd0);
    chk("async reset result", MulDivResult, 32'd0);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    dseen = 0; bseen = 0;
    repeat (W + 8) begin
      @(posedge clk); #1;
      if (Done) dseen++;
      if (Busy) bseen++;
    end
    chk("abandoned op no done", 32'(dseen), 32'd0);
    chk("abandoned op not busy", 32'(bseen), 32'd0);
    run("MUL after reset", 3'd0, 32'd12345, 32'd678, 32'd8369910, LAT_NORM);

    // Randomized ops against the reference model
    for (int i = 0; i < 150; i++) begin
      f   = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      a   = $urandom;
      b   = $urandom;
      case (sel)
        0: b = 32'd0;
        1: begin a = MOST_NEG; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 40)); b = 32'($urandom_range(1, 9)); end
        3: b = 32'($urandom_range(1, 5));
        4: begin a = -32'($urandom_range(0, 40)); b = -32'($urandom_range(1, 9)); end
        5: a = MOST_NEG;
        default: ;
      endcase
      run($sformatf("rand%0d f=%0d a=%08h b=%08h", i, f, a, b), f, a, b,
          model(f, a, b), model_lat(f, a, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
